aclock_multi: RTL

- Parametrised successor to the single-alarm BCD alarm clock.
- Keeps the 24 h HH:MM:SS BCD timekeeper.
- Adds NUM_ALARMS independently armed alarm channels, a clk-to-second prescaler, an automatic ring timeout and load validation.
- Sits behind the time-config and alarm-operation interfaces as a drop-in for the single-alarm clock.

---
 rtl/aclk_pkg.sv | 45 ++++
 rtl/aclk_alarm_chan.sv | 141 ++++++++++++++
 rtl/aclock_multi.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/aclk_pkg.sv
// Shared types and helpers for the multi-alarm BCD clock.
//
// Contents:
//   bcd_hm_t     packed HH:MM in BCD (h1, h0, m1, m0)
//   bcd_hms_t    packed HH:MM:SS in BCD (hm, s1, s0)
//   al_state_e   alarm channel state (IDLE, RINGING, SNOOZED)
//   MAX_H1, MAX_M1, SEC_PER_MIN  digit limits and minute length
//   bcd_hm_valid() true when an HH:MM value is a legal 24 h time
package aclk_pkg;

    localparam int MAX_H1      = 2;
    localparam int MAX_M1      = 5;
    localparam int SEC_PER_MIN = 60;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [2:0] m1;
        logic [3:0] m0;
    } bcd_hm_t;

    typedef struct packed {
        bcd_hm_t    hm;
        logic [2:0] s1;
        logic [3:0] s0;
    } bcd_hms_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } al_state_e;

    // Hours 00..23, minutes 00..59, every unit digit a decimal digit.
    function automatic logic bcd_hm_valid(input bcd_hm_t t);
        logic ok;
        ok = (t.h1 <= 2'(MAX_H1)) && (t.h0 <= 4'd9) &&
             (t.m1 <= 3'(MAX_M1)) && (t.m0 <= 4'd9);
        if (t.h1 == 2'(MAX_H1) && t.h0 > 4'd3) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/aclk_alarm_chan.sv
// One alarm channel: alarm time register, ring FSM and ring timeout.
//
// With ACLK_SNOOZE_EN defined the channel also supports snoozing
// (SNOOZED state, snooze input, minute-based snooze countdown).
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   tick      one-cycle pulse each time the clock's seconds advance
//   time_upd  the time register changed on the previous edge
//   time_now  current time register contents
//   wr_en     write wr_val into this channel's alarm register
//   wr_val    validated alarm time
//   al_on     arm bit for this channel
//   stop      stop request, shared by all channels
//   snooze    snooze request (ACLK_SNOOZE_EN only)
//   alarm     channel is ringing
module aclk_alarm_chan
    import aclk_pkg::*;
#(
    parameter int RING_SECONDS = 60
`ifdef ACLK_SNOOZE_EN
    ,
    parameter int SNOOZE_MIN = 5
`endif
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     tick,
    input  logic     time_upd,
    input  bcd_hms_t time_now,
    input  logic     wr_en,
    input  bcd_hm_t  wr_val,
    input  logic     al_on,
    input  logic     stop,
`ifdef ACLK_SNOOZE_EN
    input  logic     snooze,
`endif
    output logic     alarm
);

    localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);

    al_state_e  state_q, state_d;
    bcd_hm_t    alarm_q;
    logic [7:0] ring_q, ring_d;
    logic       match;

`ifdef ACLK_SNOOZE_EN
    localparam logic [15:0] SNZ_LOAD = 16'(SNOOZE_MIN * SEC_PER_MIN);
    logic [15:0] snz_q, snz_d;
`endif

    // The time register is compared one cycle after it changed, so the
    // alarm output rises on the edge after the matching time is visible.
    assign match = time_upd && al_on &&
                   (time_now.hm == alarm_q) &&
                   (time_now.s1 == 3'd0) && (time_now.s0 == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (!reset) begin
            state_q <= IDLE;
            ring_q  <= '0;
            // NOTE: the alarm time lives in ordinary flops, not a RAM
            // macro, so it takes the async reset and powers up at 00:00.
            alarm_q <= '0;
`ifdef ACLK_SNOOZE_EN
            snz_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
`ifdef ACLK_SNOOZE_EN
            snz_q   <= snz_d;
`endif
            // A write never disturbs the FSM: a ringing channel keeps ringing.
            if (wr_en) begin
                alarm_q <= wr_val;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case leaves one unassigned and infers a latch.
        state_d = state_q;
        ring_d  = ring_q;
`ifdef ACLK_SNOOZE_EN
        snz_d   = snz_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (match && !stop) begin
                    state_d = RINGING;
                    ring_d  = '0;
                end
            end
            RINGING: begin
                if (stop || !al_on) begin
                    state_d = IDLE;
`ifdef ACLK_SNOOZE_EN
                end else if (snooze) begin
                    state_d = SNOOZED;
                    snz_d   = SNZ_LOAD;
`endif
                end else if (tick) begin
                    if (ring_q == RING_LAST) begin
                        state_d = IDLE;
                    end else begin
                        ring_d = ring_q + 8'd1;
                    end
                end
            end
`ifdef ACLK_SNOOZE_EN
            SNOOZED: begin
                if (stop || !al_on) begin
                    state_d = IDLE;
                end else if (tick) begin
                    // The tick that takes the countdown to zero re-arms the
                    // ring, so the channel stays silent for exactly SNZ_LOAD ticks.
                    if (snz_q <= 16'd1) begin
                        state_d = RINGING;
                        ring_d  = '0;
                        snz_d   = '0;
                    end else begin
                        snz_d = snz_q - 16'd1;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign alarm = (state_q == RINGING);

endmodule

// File: rtl/aclock_multi.sv
// 24 h BCD alarm clock with NUM_ALARMS independent alarm channels.
//
// Holds the HH:MM:SS timekeeper, the clk-to-second prescaler and load
// validation; each alarm channel is an aclk_alarm_chan instance.
// Optional feature macro: ACLK_SNOOZE_EN (adds SNOOZE input and snoozing).
//
// Ports:
//   clk, reset          clock (rising edge), async active-low reset
//   H_in1/H_in0         hour tens/units to load, BCD
//   M_in1/M_in0         minute tens/units to load, BCD
//   LD_time             load H/M inputs into the time register
//   LD_alarm            load H/M inputs into alarm channel AL_SEL
//   AL_SEL              alarm channel index
//   AL_ON               per-channel arm mask
//   STOP_al             stop every ringing (or snoozed) channel
//   SNOOZE              snooze ringing channels (ACLK_SNOOZE_EN only)
//   Alarm / Alarm_any   per-channel ringing flags and their OR
//   ld_err              one-cycle pulse after a rejected load
//   H_out*, M_out*, S_out*  current time, BCD
module aclock_multi
    import aclk_pkg::*;
#(
    parameter int NUM_ALARMS    = 4,
    parameter int TICKS_PER_SEC = 10,
    parameter int RING_SECONDS  = 60,
    parameter int SNOOZE_MIN    = 5,
    localparam int ASW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            H_in1,
    input  logic [3:0]            H_in0,
    input  logic [2:0]            M_in1,
    input  logic [3:0]            M_in0,
    input  logic                  LD_time,
    input  logic                  LD_alarm,
    input  logic [ASW-1:0]        AL_SEL,
    input  logic [NUM_ALARMS-1:0] AL_ON,
    input  logic                  STOP_al,
`ifdef ACLK_SNOOZE_EN
    input  logic                  SNOOZE,
`endif
    output logic [NUM_ALARMS-1:0] Alarm,
    output logic                  Alarm_any,
    output logic                  ld_err,
    output logic [1:0]            H_out1,
    output logic [3:0]            H_out0,
    output logic [2:0]            M_out1,
    output logic [3:0]            M_out0,
    output logic [2:0]            S_out1,
    output logic [3:0]            S_out0
);

    localparam int              PW         = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    if (NUM_ALARMS < 1 || NUM_ALARMS > 16) begin : g_bad_num_alarms
        $error("aclock_multi: NUM_ALARMS must be 1..16");
    end
    if (TICKS_PER_SEC < 2) begin : g_bad_ticks
        $error("aclock_multi: TICKS_PER_SEC must be at least 2");
    end
    if (RING_SECONDS < 1 || RING_SECONDS > 255) begin : g_bad_ring
        $error("aclock_multi: RING_SECONDS must be 1..255");
    end
    if (SNOOZE_MIN < 1 || SNOOZE_MIN * SEC_PER_MIN > 65535) begin : g_bad_snooze
        $error("aclock_multi: SNOOZE_MIN out of range");
    end

    logic [PW-1:0]         presc_q;
    bcd_hms_t              time_q, time_inc;
    bcd_hm_t               in_hm;
    logic                  tick, sec_tick;
    logic                  in_ok, sel_ok;
    logic                  ld_time_ok, ld_alarm_ok;
    logic                  time_upd_q;
    logic [NUM_ALARMS-1:0] wr_en;

    assign in_hm       = '{h1: H_in1, h0: H_in0, m1: M_in1, m0: M_in0};
    assign in_ok       = bcd_hm_valid(in_hm);
    assign sel_ok      = int'(AL_SEL) < NUM_ALARMS;
    assign ld_time_ok  = LD_time && in_ok;
    assign ld_alarm_ok = LD_alarm && in_ok && sel_ok;
    assign tick        = (presc_q == PRESC_LAST);
    // A valid time load restarts the second, so a coincident tick is dropped
    // for the channels as well as for the timekeeper.
    assign sec_tick    = tick && !ld_time_ok;

    // One-second increment through the BCD carry chain; 23:59:59 wraps to 00:00:00.
    always_comb begin
        time_inc = time_q;
        if (time_q.s0 != 4'd9) begin
            time_inc.s0 = time_q.s0 + 4'd1;
        end else begin
            time_inc.s0 = '0;
            if (time_q.s1 != 3'(MAX_M1)) begin
                time_inc.s1 = time_q.s1 + 3'd1;
            end else begin
                time_inc.s1 = '0;
                if (time_q.hm.m0 != 4'd9) begin
                    time_inc.hm.m0 = time_q.hm.m0 + 4'd1;
                end else begin
                    time_inc.hm.m0 = '0;
                    if (time_q.hm.m1 != 3'(MAX_M1)) begin
                        time_inc.hm.m1 = time_q.hm.m1 + 3'd1;
                    end else begin
                        time_inc.hm.m1 = '0;
                        if (time_q.hm.h1 == 2'(MAX_H1) && time_q.hm.h0 == 4'd3) begin
                            time_inc.hm.h1 = '0;
                            time_inc.hm.h0 = '0;
                        end else if (time_q.hm.h0 == 4'd9) begin
                            time_inc.hm.h0 = '0;
                            time_inc.hm.h1 = time_q.hm.h1 + 2'd1;
                        end else begin
                            time_inc.hm.h0 = time_q.hm.h0 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // An invalid LD_time is simply ignored: the prescaler and a coincident
    // tick proceed as if no load had been requested.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q    <= '0;
            time_q     <= '0;
            time_upd_q <= 1'b0;
            ld_err     <= 1'b0;
        end else begin
            if (ld_time_ok) begin
                time_q  <= '{hm: in_hm, s1: 3'd0, s0: 4'd0};
                presc_q <= '0;
            end else begin
                presc_q <= tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    time_q <= time_inc;
                end
            end
            time_upd_q <= ld_time_ok || tick;
            ld_err     <= (LD_time && !in_ok) || (LD_alarm && !(in_ok && sel_ok));
        end
    end

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_chan
        assign wr_en[i] = ld_alarm_ok && (int'(AL_SEL) == i);

        aclk_alarm_chan #(
            .RING_SECONDS (RING_SECONDS)
`ifdef ACLK_SNOOZE_EN
            ,
            .SNOOZE_MIN   (SNOOZE_MIN)
`endif
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .tick     (sec_tick),
            .time_upd (time_upd_q),
            .time_now (time_q),
            .wr_en    (wr_en[i]),
            .wr_val   (in_hm),
            .al_on    (AL_ON[i]),
            .stop     (STOP_al),
`ifdef ACLK_SNOOZE_EN
            .snooze   (SNOOZE),
`endif
            .alarm    (Alarm[i])
        );
    end

    assign Alarm_any = |Alarm;

    assign H_out1 = time_q.hm.h1;
    assign H_out0 = time_q.hm.h0;
    assign M_out1 = time_q.hm.m1;
    assign M_out0 = time_q.hm.m0;
    assign S_out1 = time_q.s1;
    assign S_out0 = time_q.s0;

endmodule
